branch_resolve_ctrl: RTL
========================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a taken branch (legal range 1..7).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port br_valid  input  1  branch/jump offered by ID/EX stage.
REQ-005 SHALL have port br_ready  output  1  controller can accept a branch.
REQ-006 SHALL have ports br_funct3 (input, 3), br_is_jal (input, 1) and br_is_jalr (input, 1), carrying the instruction class.
REQ-007 SHALL have ports rs1_value, rs2_value, br_pc and br_imm, each input 32, giving the operands, instruction PC and sign-extended immediate.
REQ-008 SHALL have ports resolve_valid (output, 1) and resolve_taken (output, 1), a one-cycle resolution result.
REQ-009 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32), a one-cycle fetch redirect.
REQ-010 SHALL have ports flush (output, 1), which kills IF/ID, and fault_pulse (output, 1), which flags an illegal funct3 or misaligned target.

Function
REQ-011 SHALL implement FSM states IDLE, EVAL, REDIRECT.
REQ-012 SHALL assert br_ready only in IDLE; handshake = br_valid && br_ready.
REQ-013 SHALL, on handshake, register all br_* and rs*_value inputs and move IDLE->EVAL; inputs are ignored outside handshake.
REQ-014 SHALL, in EVAL, compute taken: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; jal/jalr are always taken; jal takes priority over jalr, and jalr over funct3.
REQ-015 SHALL compute the target as pc+imm for branch/jal, and (rs1+imm) with bit0 cleared for jalr, with 32-bit wrap-around and carry discarded.
REQ-016 SHALL treat funct3 010/011 on a non-jump as not taken and pulse fault_pulse in EVAL.
REQ-017 SHALL treat a taken target with bit1 set as misaligned: fault_pulse, no redirect, resolve_taken=0.
REQ-018 SHALL pulse resolve_valid for exactly one cycle in EVAL (handshake + 1); EVAL->IDLE when not taken.
REQ-019 SHALL, when taken and aligned, pulse redirect_valid with redirect_pc in EVAL and go EVAL->REDIRECT.
REQ-020 SHALL assert flush from EVAL through the REDIRECT countdown, FLUSH_CYCLES cycles total, then return to IDLE; br_ready stays low throughout.
REQ-021 SHALL hold redirect_pc at its last value when redirect_valid is low.
REQ-022 SHALL never issue back-to-back handshakes closer than 2 cycles; a br_valid held across EVAL is accepted on the first IDLE cycle.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-EVAL or mid-REDIRECT, force IDLE immediately and set br_ready=0 while reset is asserted, with resolve_valid, resolve_taken, redirect_valid, flush and fault_pulse all 0, redirect_pc=0 and the counters at 0.
REQ-024 SHALL drive br_ready=1 in the first cycle after rst_n deasserts; no pending branch survives reset.

Configuration
REQ-025 SHALL, with BRANCH_STATS_EN defined, add outputs taken_cnt and resolve_cnt (16 each), incremented on taken and on every resolve_valid respectively, saturating at 16'hFFFF.
REQ-026 SHALL, without BRANCH_STATS_EN, omit those ports and counters entirely, with all other behaviour identical.

Verification
REQ-027 SHALL verify: BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20 -> resolve_valid at +1, redirect_pc=0x120, flush for 2 cycles, br_ready back at +3.
REQ-028 SHALL verify: BLT, rs1=0xFFFFFFFF, rs2=0x1 -> taken; BLTU with the same operands -> not taken, no flush, br_ready at +2.
REQ-029 SHALL verify: JALR, rs1=0x203, imm=0x1 -> redirect_pc=0x204; rs1=0x201, imm=0x1 -> fault_pulse, no redirect.
REQ-030 SHALL verify: funct3=010 non-jump -> fault_pulse=1, resolve_taken=0, no flush.
REQ-031 SHALL verify: rst_n low during REDIRECT -> flush=0 at once, br_ready=1 on the first cycle after release, and (with BRANCH_STATS_EN) counters=0.
REQ-032 SHALL verify: pc=0xFFFFFFF0, imm=0x20 taken -> redirect_pc=0x00000010.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution controller: evaluates a captured branch, redirects fetch and holds flush.
// Optional BRANCH_STATS_EN adds saturating taken/resolve counters.
module branch_resolve_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  br_funct3,
   input  logic        br_is_jal,
   input  logic        br_is_jalr,
   input  logic [31:0] rs1_value,
   input  logic [31:0] rs2_value,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   output logic        resolve_valid,
   output logic        resolve_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        fault_pulse
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0] taken_cnt,
   output logic [15:0] resolve_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

   state_t      state;
   state_t      next_state;
   logic [2:0]  funct3_q;
   logic        jal_q;
   logic        jalr_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic [31:0] pc_q;
   logic [31:0] imm_q;
   logic [31:0] redirect_pc_q;
   logic [2:0]  flush_cnt;

   logic        handshake;
   logic        cond_taken;
   logic        illegal;
   logic        raw_taken;
   logic        misaligned;
   logic        redirect_ok;
   logic [31:0] target;

   assign handshake = br_valid && br_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q <= 3'd0;
         jal_q    <= 1'b0;
         jalr_q   <= 1'b0;
         rs1_q    <= 32'd0;
         rs2_q    <= 32'd0;
         pc_q     <= 32'd0;
         imm_q    <= 32'd0;
      end else if (handshake) begin
         funct3_q <= br_funct3;
         jal_q    <= br_is_jal;
         jalr_q   <= br_is_jalr;
         rs1_q    <= rs1_value;
         rs2_q    <= rs2_value;
         pc_q     <= br_pc;
         imm_q    <= br_imm;
      end
   end

   // Condition evaluation and target generation from the captured operands
   always_comb begin
      cond_taken = 1'b0;
      illegal    = 1'b0;
      case (funct3_q)
         3'b000:  cond_taken = (rs1_q == rs2_q);
         3'b001:  cond_taken = (rs1_q != rs2_q);
         3'b100:  cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
         3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
         3'b110:  cond_taken = (rs1_q <  rs2_q);
         3'b111:  cond_taken = (rs1_q >= rs2_q);
         default: illegal    = !(jal_q || jalr_q);
      endcase
      raw_taken = jal_q || jalr_q || cond_taken;
      if (!jal_q && jalr_q) begin
         target = (rs1_q + imm_q) & 32'hFFFF_FFFE;
      end else begin
         target = pc_q + imm_q;
      end
      misaligned  = raw_taken && target[1];
      redirect_ok = raw_taken && !misaligned;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (handshake) begin
               next_state = EVAL;
            end
         end
         EVAL: begin
            if (redirect_ok && (FLUSH_CYCLES > 1)) begin
               next_state = REDIRECT;
            end else begin
               next_state = IDLE;
            end
         end
         REDIRECT: begin
            if (flush_cnt <= 3'd1) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      br_ready       = (state == IDLE) && rst_n;
      resolve_valid  = (state == EVAL);
      resolve_taken  = (state == EVAL) && redirect_ok;
      redirect_valid = (state == EVAL) && redirect_ok;
      flush          = ((state == EVAL) && redirect_ok) || (state == REDIRECT);
      fault_pulse    = (state == EVAL) && (illegal || misaligned);
      redirect_pc    = redirect_valid ? target : redirect_pc_q;
   end

   // The EVAL cycle is the first flush cycle; the countdown covers the remainder
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt     <= 3'd0;
         redirect_pc_q <= 32'd0;
      end else begin
         if (redirect_valid) begin
            redirect_pc_q <= target;
            flush_cnt     <= 3'(FLUSH_CYCLES - 1);
         end else if ((state == REDIRECT) && (flush_cnt != 3'd0)) begin
            flush_cnt <= flush_cnt - 3'd1;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt   <= 16'd0;
         resolve_cnt <= 16'd0;
      end else begin
         if (resolve_taken && (taken_cnt != 16'hFFFF)) begin
            taken_cnt <= taken_cnt + 16'd1;
         end
         if (resolve_valid && (resolve_cnt != 16'hFFFF)) begin
            resolve_cnt <= resolve_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
